// File: rtl/rtlmem_nr1w_clr.sv
// rtl/rtlmem_nr1w_clr.sv - N-read/1-write RAM with write-first bypass, read-valid and clear engine
module rtlmem_nr1w_clr #(
  parameter int                 G_NRD      = 4,
  parameter int                 G_ADDR     = 4,
  parameter int                 G_WIDTH    = 8,
  parameter int                 G_DEPTH    = 2**G_ADDR,
  parameter int                 G_PIPELINE = 1,
  parameter logic [G_WIDTH-1:0] G_RST_VAL  = '0,
  parameter bit                 G_AUTOCLR  = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clren,
  output logic                     o_clrrdy,
  input  logic                     i_memwe,
  input  logic [G_ADDR-1:0]        i_memwa,
  input  logic [G_WIDTH-1:0]       i_memdi,
  input  logic [G_NRD-1:0]         i_memre,
  input  logic [G_NRD*G_ADDR-1:0]  i_memra,
  output logic [G_NRD*G_WIDTH-1:0] o_memdo,
  output logic [G_NRD-1:0]         o_memvld
);

  localparam logic [G_ADDR:0]   LP_DEPTH = (G_ADDR+1)'(G_DEPTH);
  localparam logic [G_ADDR-1:0] LP_LAST  = G_ADDR'(G_DEPTH-1);

  typedef enum logic {S_IDLE, S_CLR} state_t;

  state_t             r_state;
  logic [G_ADDR-1:0]  r_clrcnt;
  logic               r_clrrdy;
  logic [G_WIDTH-1:0] r_mem [G_DEPTH];

  logic               w_wen;
  logic [G_ADDR-1:0]  w_waddr;
  logic [G_WIDTH-1:0] w_wdata;
  logic [G_ADDR-1:0]  w_ra   [G_NRD];
  logic [G_WIDTH-1:0] w_rdat [G_NRD];
  logic [G_WIDTH-1:0] r_do1  [G_NRD];
  logic [G_NRD-1:0]   r_vld1;
  logic [G_WIDTH-1:0] w_dout [G_NRD];
  logic [G_NRD-1:0]   w_vout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= G_AUTOCLR ? S_CLR : S_IDLE;
      r_clrcnt <= '0;
      r_clrrdy <= !G_AUTOCLR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clren) begin
            r_state  <= S_CLR;
            r_clrcnt <= '0;
            r_clrrdy <= 1'b0;
          end
        end
        S_CLR: begin
          if (r_clrcnt == LP_LAST) begin
            r_state  <= S_IDLE;
            r_clrcnt <= '0;
            r_clrrdy <= 1'b1;
          end else begin
            r_clrcnt <= r_clrcnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_clrrdy <= 1'b1;
        end
      endcase
    end
  end

  // The clear sweep owns the single write port; user writes only land in IDLE.
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = i_memwa;
    w_wdata = i_memdi;
    if (r_state == S_CLR) begin
      w_wen   = i_rst_n;
      w_waddr = r_clrcnt;
      w_wdata = G_RST_VAL;
    end else if (i_rst_n && i_memwe && ({1'b0, i_memwa} < LP_DEPTH)) begin
      w_wen = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wen) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < G_NRD; i++) begin
      w_rdat[i] = G_RST_VAL;
      if (r_state == S_IDLE && ({1'b0, w_ra[i]} < LP_DEPTH)) begin
        if (w_wen && (w_waddr == w_ra[i])) begin
          w_rdat[i] = w_wdata;
        end else begin
          w_rdat[i] = r_mem[w_ra[i]];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld1 <= '0;
      for (int i = 0; i < G_NRD; i++) begin
        r_do1[i] <= G_RST_VAL;
      end
    end else begin
      r_vld1 <= i_memre;
      for (int i = 0; i < G_NRD; i++) begin
        if (i_memre[i]) begin
          r_do1[i] <= w_rdat[i];
        end
      end
    end
  end

  generate
    if (G_PIPELINE == 2) begin : g_pipe2
      logic [G_WIDTH-1:0] r_do2 [G_NRD];
      logic [G_NRD-1:0]   r_vld2;

      // First stage already holds on idle ports, so copying it keeps the hold.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_vld2 <= '0;
          for (int i = 0; i < G_NRD; i++) begin
            r_do2[i] <= G_RST_VAL;
          end
        end else begin
          r_vld2 <= r_vld1;
          for (int i = 0; i < G_NRD; i++) begin
            r_do2[i] <= r_do1[i];
          end
        end
      end

      assign w_dout = r_do2;
      assign w_vout = r_vld2;
    end else begin : g_pipe1
      assign w_dout = r_do1;
      assign w_vout = r_vld1;
    end
  endgenerate

  for (genvar g = 0; g < G_NRD; g++) begin : g_port
    assign w_ra[g]                        = i_memra[g*G_ADDR +: G_ADDR];
    assign o_memdo[g*G_WIDTH +: G_WIDTH]  = w_dout[g];
  end

  assign o_memvld = w_vout;
  assign o_clrrdy = r_clrrdy;

endmodule

// File: tb/tb_rtlmem_nr1w_clr.sv
// tb/tb_rtlmem_nr1w_clr.sv - self-checking bench for rtlmem_nr1w_clr
module tb_rtlmem_nr1w_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clren, memwe;
  logic [3:0]  memwa;
  logic [7:0]  memdi;
  logic [3:0]  memre;
  logic [15:0] memra;
  logic        clrrdy;
  logic [31:0] memdo;
  logic [3:0]  memvld;

  logic        rst2_n, clren2, memwe2;
  logic [3:0]  memwa2;
  logic [7:0]  memdi2;
  logic [1:0]  memre2;
  logic [7:0]  memra2;
  logic        clrrdy2;
  logic [15:0] memdo2;
  logic [1:0]  memvld2;

  rtlmem_nr1w_clr dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clren(clren), .o_clrrdy(clrrdy),
    .i_memwe(memwe), .i_memwa(memwa), .i_memdi(memdi),
    .i_memre(memre), .i_memra(memra), .o_memdo(memdo), .o_memvld(memvld)
  );

  rtlmem_nr1w_clr #(
    .G_NRD(2), .G_ADDR(4), .G_WIDTH(8), .G_DEPTH(12), .G_PIPELINE(2),
    .G_RST_VAL(8'h5A), .G_AUTOCLR(1'b1)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_clren(clren2), .o_clrrdy(clrrdy2),
    .i_memwe(memwe2), .i_memwa(memwa2), .i_memdi(memdi2),
    .i_memre(memre2), .i_memra(memra2), .o_memdo(memdo2), .o_memvld(memvld2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: array contents, remaining clear cycles, expected outputs.
  logic [7:0] mmem [16];
  int         busy;
  logic [7:0] edo  [4];
  logic [3:0] evld;
  logic       erdy;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  di;
    logic [3:0]  re;
    logic [15:0] ra;
    logic [31:0] edo;
    logic [3:0]  evld;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] a;
    if (!rst_n) begin
      busy = 16;
      evld = '0;
      for (int i = 0; i < 4; i++) edo[i] = 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (memre[i]) begin
          a = memra[i*4 +: 4];
          if (busy > 0)                    edo[i] = 8'h00;
          else if (memwe && memwa == a)    edo[i] = memdi;
          else                             edo[i] = mmem[a];
        end
      end
      evld = memre;
      if (busy > 0) begin
        mmem[16-busy] = 8'h00;
        busy--;
      end else begin
        if (memwe) mmem[memwa] = memdi;
        if (clren) busy = 16;
      end
    end
    erdy = (busy == 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("clrrdy", {31'd0, clrrdy}, {31'd0, erdy});
    chk("memvld", {28'd0, memvld}, {28'd0, evld});
    for (int i = 0; i < 4; i++)
      chk($sformatf("memdo%0d", i), {24'd0, memdo[i*8 +: 8]}, {24'd0, edo[i]});
  endtask

  task automatic cycle2();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] f2(input int a);
    return (a < 12) ? 8'(8'h10 + a) : 8'h5A;
  endfunction

  logic [1:0] pre_re, cur_re;
  int         pre_a0, pre_a1;
  logic [7:0] h0, h1;

  initial begin
    rst_n = 1'b0; clren = 1'b0; memwe = 1'b0; memwa = '0; memdi = '0; memre = '0; memra = '0;
    rst2_n = 1'b0; clren2 = 1'b0; memwe2 = 1'b0; memwa2 = '0; memdi2 = '0; memre2 = '0; memra2 = '0;
    busy = 0; evld = '0; erdy = 1'b0;
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
    for (int i = 0; i < 4; i++) edo[i] = 8'h00;

    tbl[0] = '{1'b1, 4'd3, 8'hA5, 4'b0000, 16'h0000, 32'h0000_0000, 4'b0000};
    tbl[1] = '{1'b1, 4'd7, 8'h3C, 4'b0000, 16'h0000, 32'h0000_0000, 4'b0000};
    tbl[2] = '{1'b0, 4'd0, 8'h00, 4'b1111, 16'h0373, 32'h00A5_3CA5, 4'b1111};
    tbl[3] = '{1'b1, 4'd5, 8'h11, 4'b0000, 16'h0000, 32'h00A5_3CA5, 4'b0000};
    tbl[4] = '{1'b1, 4'd5, 8'h99, 4'b0100, 16'h0500, 32'h0099_3CA5, 4'b0100};
    tbl[5] = '{1'b0, 4'd0, 8'h00, 4'b0001, 16'h0005, 32'h0099_3C99, 4'b0001};
    tbl[6] = '{1'b0, 4'd0, 8'h00, 4'b1000, 16'h7000, 32'h3C99_3C99, 4'b1000};
    tbl[7] = '{1'b0, 4'd0, 8'h00, 4'b1111, 16'h3333, 32'hA5A5_A5A5, 4'b1111};

    @(negedge clk);

    // Reset then automatic sweep, reading port 0 throughout
    repeat (2) cycle();
    rst_n = 1'b1;
    memre = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      memra = {12'h000, 4'(k)};
      cycle();
      chk("autoclr_rdy", {31'd0, clrrdy}, {31'd0, (k == 15)});
    end
    for (int k = 0; k < 16; k++) begin
      memra = {12'h000, 4'(k)};
      cycle();
      chk("rd0_data", {24'd0, memdo[7:0]}, 32'h00);
      chk("rd0_vld", {28'd0, memvld}, 32'h1);
    end
    memre = '0;

    for (int k = 0; k < 8; k++) begin
      memwe = tbl[k].we; memwa = tbl[k].wa; memdi = tbl[k].di;
      memre = tbl[k].re; memra = tbl[k].ra;
      cycle();
      chk($sformatf("tbl%0d_do", k), memdo, tbl[k].edo);
      chk($sformatf("tbl%0d_vld", k), {28'd0, memvld}, {28'd0, tbl[k].evld});
    end
    memwe = 1'b0; memre = '0;

    // Fill with FF, then clear on request with a dropped mid-sweep write
    for (int a = 0; a < 16; a++) begin
      memwe = 1'b1; memwa = 4'(a); memdi = 8'hFF;
      cycle();
    end
    memwe = 1'b0;
    memre = 4'b0001; memra = 16'h0005;
    cycle();
    chk("fill_ff", {24'd0, memdo[7:0]}, 32'hFF);
    memre = '0;
    clren = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cycle();
      chk("clrreq_rdy", {31'd0, clrrdy}, {31'd0, (k == 16)});
      clren = 1'b0;
      memwe = (k == 7); memwa = 4'd2; memdi = 8'h77;
    end
    memwe = 1'b0;
    memre = 4'b0010; memra = 16'h0020;
    cycle();
    chk("clr_drop", {24'd0, memdo[15:8]}, 32'h00);

    // Reset in the middle of a sweep
    memre = '0; clren = 1'b1;
    cycle();
    clren = 1'b0; memre = 4'b1111; memra = 16'h3210;
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_vld", {28'd0, memvld}, 32'h0);
    chk("midrst_do", memdo, 32'h0);
    chk("midrst_rdy", {31'd0, clrrdy}, 32'h0);
    rst_n = 1'b1; memre = '0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("midrst_sweep", {31'd0, clrrdy}, {31'd0, (k == 15)});
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      clren = ($urandom_range(0, 79) == 0);
      memwe = 1'($urandom_range(0, 1));
      memwa = 4'($urandom);
      memdi = 8'($urandom);
      memre = 4'($urandom);
      memra = 16'($urandom);
      cycle();
    end
    rst_n = 1'b1; clren = 1'b0; memwe = 1'b0; memre = '0;

    // Two-port, two-stage instance with depth 12 and non-zero clear value
    repeat (2) cycle2();
    rst2_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle2();
      chk("p2_clr_rdy", {31'd0, clrrdy2}, {31'd0, (k == 11)});
    end
    for (int a = 0; a < 12; a++) begin
      memwe2 = 1'b1; memwa2 = 4'(a); memdi2 = f2(a);
      cycle2();
    end
    memwa2 = 4'd13; memdi2 = 8'h33;
    cycle2();
    memwe2 = 1'b0;

    pre_re = 2'b00; pre_a0 = 0; pre_a1 = 0;
    h0 = 8'h5A; h1 = 8'h5A;
    for (int t = 0; t < 18; t++) begin
      cur_re = (t < 16 && t != 6) ? 2'b11 : 2'b00;
      memre2 = cur_re;
      memra2 = {4'(15 - t), 4'(t)};
      cycle2();
      if (pre_re[0]) h0 = f2(pre_a0);
      if (pre_re[1]) h1 = f2(pre_a1);
      chk("p2_vld", {30'd0, memvld2}, {30'd0, pre_re});
      chk("p2_do0", {24'd0, memdo2[7:0]}, {24'd0, h0});
      chk("p2_do1", {24'd0, memdo2[15:8]}, {24'd0, h1});
      pre_re = cur_re; pre_a0 = t; pre_a1 = 15 - t;
    end

    memwe2 = 1'b1; memwa2 = 4'd4; memdi2 = 8'h77;
    memre2 = 2'b10; memra2 = 8'h40;
    cycle2();
    memwe2 = 1'b0; memre2 = 2'b00;
    chk("p2_byp_lat", {30'd0, memvld2}, 32'h0);
    cycle2();
    chk("p2_byp_vld", {30'd0, memvld2}, 32'h2);
    chk("p2_byp_do", {24'd0, memdo2[15:8]}, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
